ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter, the send side of the keyboard link. It sends command bytes to the keyboard, such as 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset). Sits beside the ps2 receiver and drives the shared PS2_CLK/PS2_DAT lines through open-drain enables; the top level builds the tri-states. Raises rx_inhibit so the receiver ignores line activity during a host frame.

---
 rtl/ps2_host_tx_if.sv | 26 ++
 rtl/ps2_host_tx.sv | 202 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
// PS/2 host transmitter bus: byte request handshake, raw line levels and
// the open-drain pull enables that the top level turns into tri-states.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;
    logic       rx_inhibit;

    // Transmitter side.
    modport slave (
        input  tx_data, tx_start, ps2_clk_in, ps2_dat_in,
        output ps2_clk_oe, ps2_dat_oe, tx_busy, tx_done, tx_error, rx_inhibit
    );

    // Requester / line side.
    modport master (
        output tx_data, tx_start, ps2_clk_in, ps2_dat_in,
        input  ps2_clk_oe, ps2_dat_oe, tx_busy, tx_done, tx_error, rx_inhibit
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Inhibits the bus, issues the start bit,
// shifts D0..D7, odd parity and stop bit on device clock falls, samples the
// device ACK, then waits for both lines to go idle. A watchdog bounds the
// whole device-clocked part of the frame.
// Optional macro PS2_HOST_TX_RETRY_EN: on NACK or timeout the frame is re-run
// once with the same byte before tx_done/tx_error are reported.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic         iCLK_50,
    input  logic         iRST_n,
    ps2_host_tx_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

`ifdef PS2_HOST_TX_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    state_t                 state_q,    state_d;
    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    logic [7:0]             data_q,     data_d;
    logic                   parity_q,   parity_d;
    logic [3:0]             bit_cnt_q,  bit_cnt_d;
    logic [INH_W-1:0]       inh_cnt_q,  inh_cnt_d;
    logic [WD_W-1:0]        wdog_q,     wdog_d;
    logic                   clk_oe_q,   clk_oe_d;
    logic                   dat_oe_q,   dat_oe_d;
    logic                   done_q,     done_d;
    logic                   err_q,      err_d;
    logic                   nack_q,     nack_d;
    logic                   retry_q,    retry_d;

    logic clk_s, dat_s, clk_fall;
    logic in_frame, wd_expired, inh_over, line_idle;
    logic frame_end, frame_fail, do_retry;

    assign clk_s      = clk_sync_q[SYNC_STAGES-1];
    assign dat_s      = dat_sync_q[SYNC_STAGES-1];
    assign clk_fall   = clk_prev_q & ~clk_s;
    assign line_idle  = clk_s & dat_s;
    assign in_frame   = (state_q == S_REQ) || (state_q == S_SHIFT) ||
                        (state_q == S_ACK) || (state_q == S_WAIT_IDLE);
    assign wd_expired = in_frame && (wdog_q == WD_LAST);
    assign inh_over   = (state_q == S_INHIBIT) && (inh_cnt_q == INH_LAST);
    // A frame ends either by watchdog or by the bus returning to idle after ACK.
    assign frame_end  = wd_expired || ((state_q == S_WAIT_IDLE) && line_idle);
    assign frame_fail = wd_expired || nack_q;
    assign do_retry   = frame_end && frame_fail && RETRY_EN && !retry_q;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge iCLK_50) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values regardless of statement order.
        if (!iRST_n) begin
            state_q    <= S_IDLE;
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
            data_q     <= '0;
            parity_q   <= 1'b0;
            bit_cnt_q  <= '0;
            inh_cnt_q  <= '0;
            wdog_q     <= '0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            nack_q     <= 1'b0;
            retry_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            clk_prev_q <= clk_prev_d;
            data_q     <= data_d;
            parity_q   <= parity_d;
            bit_cnt_q  <= bit_cnt_d;
            inh_cnt_q  <= inh_cnt_d;
            wdog_q     <= wdog_d;
            clk_oe_q   <= clk_oe_d;
            dat_oe_q   <= dat_oe_d;
            done_q     <= done_d;
            err_q      <= err_d;
            nack_q     <= nack_d;
            retry_q    <= retry_d;
        end
    end

    // Next-state logic: frame sequencing plus end-of-frame / retry override.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned
        // (which would infer a latch).
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (bus.tx_start) state_d = S_INHIBIT;
            S_INHIBIT:   if (inh_over) state_d = S_REQ;
            S_REQ:       if (clk_fall) state_d = S_SHIFT;
            S_SHIFT:     if (clk_fall && (bit_cnt_q == 4'd9)) state_d = S_ACK;
            S_ACK:       if (clk_fall) state_d = S_WAIT_IDLE;
            S_WAIT_IDLE: state_d = S_WAIT_IDLE;
            default:     state_d = S_IDLE;
        endcase
        if (frame_end) state_d = do_retry ? S_INHIBIT : S_IDLE;
    end

    // Output and datapath logic: line enables, counters, status pulses.
    always_comb begin
        clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], bus.ps2_clk_in};
        dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], bus.ps2_dat_in};
        clk_prev_d = clk_s;
        data_d     = data_q;
        parity_d   = parity_q;
        bit_cnt_d  = bit_cnt_q;
        inh_cnt_d  = inh_cnt_q;
        wdog_d     = in_frame ? wdog_q + 1'b1 : wdog_q;
        clk_oe_d   = clk_oe_q;
        dat_oe_d   = dat_oe_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        nack_d     = nack_q;
        retry_d    = retry_q;

        case (state_q)
            S_IDLE: begin
                if (bus.tx_start) begin
                    data_d    = bus.tx_data;
                    parity_d  = ~^bus.tx_data;
                    clk_oe_d  = 1'b1;
                    dat_oe_d  = 1'b0;
                    inh_cnt_d = '0;
                    nack_d    = 1'b0;
                    retry_d   = 1'b0;
                end
            end
            S_INHIBIT: begin
                if (inh_over) begin
                    // Release CLK and present the start bit in the same edge.
                    clk_oe_d  = 1'b0;
                    dat_oe_d  = 1'b1;
                    bit_cnt_d = '0;
                    wdog_d    = '0;
                    nack_d    = 1'b0;
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                end
            end
            S_REQ, S_SHIFT: begin
                if (clk_fall) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q < 4'd8)       dat_oe_d = ~data_q[bit_cnt_q[2:0]];
                    else if (bit_cnt_q == 4'd8) dat_oe_d = ~parity_q;
                    else                        dat_oe_d = 1'b0;
                end
            end
            S_ACK: begin
                if (clk_fall) nack_d = dat_s;
            end
            default: ;
        endcase

        if (frame_end) begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            if (do_retry) begin
                retry_d   = 1'b1;
                clk_oe_d  = 1'b1;
                inh_cnt_d = '0;
            end else begin
                done_d = 1'b1;
                err_d  = frame_fail;
            end
        end
    end

    assign bus.ps2_clk_oe = clk_oe_q;
    assign bus.ps2_dat_oe = dat_oe_q;
    assign bus.tx_busy    = (state_q != S_IDLE);
    assign bus.rx_inhibit = (state_q != S_IDLE);
    assign bus.tx_done    = done_q;
    assign bus.tx_error   = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device drives the open-drain
// lines and captures the bits the host presents; expected frames are built
// from the byte with plain arithmetic.
module tb_ps2_host_tx;

    localparam int INH  = 50;
    localparam int TMO  = 5000;
    localparam int HALF = 20;
`ifdef PS2_HOST_TX_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic dev_clk;
    logic dev_dat;

    ps2_host_tx_if bus ();

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .SYNC_STAGES   (2)
    ) dut (
        .iCLK_50(clk),
        .iRST_n (rst_n),
        .bus    (bus)
    );

    // Wired-AND open-drain lines.
    assign bus.ps2_clk_in = ~bus.ps2_clk_oe & dev_clk;
    assign bus.ps2_dat_in = ~bus.ps2_dat_oe & dev_dat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   frame_cnt = 0;
    int   both_cnt = 0;
    int   orphan_err = 0;
    int   done_cycle = 0;
    int   req_cycle = 0;
    logic last_err = 1'b0;
    logic clk_oe_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.tx_done === 1'b1) begin
            done_cnt   <= done_cnt + 1;
            last_err   <= bus.tx_error;
            done_cycle <= cyc;
        end
        if (bus.tx_error === 1'b1 && bus.tx_done !== 1'b1) orphan_err <= orphan_err + 1;
        if (bus.ps2_clk_oe === 1'b1 && bus.ps2_dat_oe === 1'b1) both_cnt <= both_cnt + 1;
        if (bus.ps2_clk_oe === 1'b1 && !clk_oe_prev) frame_cnt <= frame_cnt + 1;
        if (bus.ps2_clk_oe === 1'b0 && clk_oe_prev && bus.ps2_dat_oe === 1'b1) req_cycle <= cyc;
        clk_oe_prev <= (bus.ps2_clk_oe === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference frame: D0..D7 LSB first, odd parity, stop bit high.
    function automatic logic [10:1] expected_frame(input logic [7:0] d);
        logic [10:1] f;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        f[9]  = (($countones(d) % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic start_tx(input logic [7:0] d);
        bus.tx_data  = d;
        bus.tx_start = 1'b1;
        tick(1);
        bus.tx_start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int limit);
        int n = 0;
        while (done_cnt == base && n < limit) begin
            tick(1);
            n++;
        end
    endtask

    // Device side of one host frame: measure inhibit, clock 11 pulses,
    // capture bits on rising edges, answer ACK/NACK on pulse 11.
    task automatic device_frame(input bit ack, input int poke_at, input int abort_at,
                                output logic [10:1] bits);
        int inh   = 0;
        int guard = 0;
        bits = '0;
        while (bus.ps2_clk_oe !== 1'b1 && guard < 1000) begin tick(1); guard++; end
        while (bus.ps2_clk_oe === 1'b1 && guard < 5000) begin inh++; tick(1); guard++; end
        check("inhibit_len", inh, INH);
        check("start_bit_busy", {bus.ps2_dat_oe, bus.tx_busy, bus.rx_inhibit}, 3'b111);
        tick(4);
        for (int k = 1; k <= 11; k++) begin
            if (k == 11) begin
                dev_dat = ack ? 1'b0 : 1'b1;
                tick(2);
            end
            dev_clk = 1'b0;
            tick(8);
            if (k == poke_at) begin
                start_tx(8'h55);
            end
            if (k == abort_at) begin
                rst_n = 1'b0;
                tick(1);
                check("reset_midframe_lines",
                      {bus.ps2_clk_oe, bus.ps2_dat_oe, bus.tx_busy, bus.tx_done}, 4'b0000);
                dev_clk = 1'b1;
                tick(3);
                rst_n = 1'b1;
                return;
            end
            tick(HALF - 8);
            dev_clk = 1'b1;
            tick(2);
            if (k <= 10) bits[k] = bus.ps2_dat_in;
            tick(HALF - 2);
        end
        dev_dat = 1'b1;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] d, input bit ack, input int poke_at);
        logic [10:1] bits;
        int base   = done_cnt;
        int fbase  = frame_cnt;
        int n_att  = (!ack && RETRY) ? 2 : 1;
        start_tx(d);
        for (int a = 0; a < n_att; a++) device_frame(ack, poke_at, 0, bits);
        check({tag, " bits"}, 32'(bits), 32'(expected_frame(d)));
        wait_done(base, 200);
        check({tag, " done"}, done_cnt - base, 1);
        check({tag, " err"}, last_err, !ack);
        check({tag, " idle"}, {bus.ps2_clk_oe, bus.ps2_dat_oe, bus.tx_busy}, 3'b000);
        tick(100);
        check({tag, " frames"}, frame_cnt - fbase, n_att);
    endtask

    initial begin
        logic [10:1] bits;
        int base;

        // Reset with a simultaneous request: reset wins.
        rst_n        = 1'b0;
        dev_clk      = 1'b1;
        dev_dat      = 1'b1;
        bus.tx_data  = 8'hED;
        bus.tx_start = 1'b1;
        tick(3);
        check("reset_outputs",
              {bus.ps2_clk_oe, bus.ps2_dat_oe, bus.tx_busy, bus.tx_done, bus.tx_error, bus.rx_inhibit},
              6'b0);
        bus.tx_start = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(5);
        check("start_in_reset_lost", {bus.tx_busy, bus.ps2_clk_oe}, 2'b00);

        // Directed bytes with known parity, then random bytes.
        run_frame("ED", 8'hED, 1'b1, 0);
        run_frame("01", 8'h01, 1'b1, 0);
        run_frame("00", 8'h00, 1'b1, 0);
        run_frame("FF", 8'hFF, 1'b1, 0);
        for (int i = 0; i < 3; i++) run_frame("rand", 8'($urandom), 1'b1, 0);

        // Device NACKs.
        run_frame("nack", 8'($urandom), 1'b0, 0);

        // Device never clocks: watchdog.
        base = done_cnt;
        start_tx(8'hF4);
        wait_done(base, 3 * TMO);
        check("timeout done", done_cnt - base, 1);
        check("timeout err", last_err, 1'b1);
        check("timeout cycles", done_cycle - req_cycle, TMO);
        check("timeout lines", {bus.ps2_clk_oe, bus.ps2_dat_oe, bus.tx_busy}, 3'b000);

        // Request while busy is dropped.
        run_frame("busy_start", 8'hA3, 1'b1, 5);

        // Reset after the fourth fall, then a clean frame.
        base = done_cnt;
        start_tx(8'hA5);
        device_frame(1'b1, 0, 4, bits);
        tick(200);
        check("no_done_after_reset", done_cnt - base, 0);
        run_frame("F4", 8'hF4, 1'b1, 0);

        check("oe_overlap", both_cnt, 0);
        check("error_without_done", orphan_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
